// File: rtl/mnist_cvxif_pkg.sv
// mnist_cvxif_pkg: shared encodings, operation enum and pipeline entry types for the dot4 coprocessor
// Ports: none (package)
package mnist_cvxif_pkg;

    localparam int CVA6ConfigXlen = 32;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
    localparam logic [6:0] FUNCT7_DOT4    = 7'h00;
    localparam logic [2:0] F3_DOT4        = 3'b000;
    localparam logic [2:0] F3_MAC4        = 3'b001;
    localparam logic [2:0] F3_ACCRD       = 3'b010;
    localparam logic [2:0] F3_RELU        = 3'b011;

    // Enum values mirror funct3[1:0] so decode is a plain cast.
    typedef enum logic [1:0] {
        OP_DOT4  = 2'd0,
        OP_MAC4  = 2'd1,
        OP_ACCRD = 2'd2,
        OP_RELU  = 2'd3
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [3:0][15:0] prod;
        logic [4:0]       rd;
        logic [31:0]      rs1;
    } s1_entry_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } s2_entry_t;

    // Sign-extends each 16-bit product to 32 bits and sums modulo 2^32.
    function automatic logic [31:0] sum4(input logic [3:0][15:0] p);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s = s + {{16{p[i][15]}}, p[i]};
        return s;
    endfunction

endpackage

// File: rtl/int8_dot4.sv
// int8_dot4: four signed 8x8 byte-lane multipliers
// Ports: a_i, b_i - packed int8 x4 operands; prod_o - four signed 16-bit lane products
module int8_dot4 (
    input  logic [31:0]       a_i,
    input  logic [31:0]       b_i,
    output logic [3:0][15:0]  prod_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic signed [15:0] a_ext, b_ext;
        assign a_ext = {{8{a_i[8*g+7]}}, a_i[8*g +: 8]};
        assign b_ext = {{8{b_i[8*g+7]}}, b_i[8*g +: 8]};
        // An int8 x int8 product always fits in 16 signed bits, so truncation is exact.
        assign prod_o[g] = a_ext * b_ext;
    end

endmodule

// File: rtl/cvxif_dot4_copro.sv
// cvxif_dot4_copro: CV-X-IF coprocessor for int8 dot4, accumulate, accumulator read and ReLU
// Ports: clk_i/rst_ni - clock, async active-low reset
//        issue_* - instruction offload handshake (valid/ready), raw instr, rs1/rs2, id, accept
//        result_* - result handshake (valid/ready), id, data, rd, we
module cvxif_dot4_copro
    import mnist_cvxif_pkg::*;
#(
    parameter int XLEN     = CVA6ConfigXlen,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    output logic                issue_accept_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o
);

    logic                s1_valid, s2_valid, advance, known;
    logic [ID_WIDTH-1:0] s1_id, s2_id;
    logic [3:0][15:0]    prod;
    logic [31:0]         acc, acc_d, dot, mac;
    op_e                 dec_op;
    s1_entry_t           s1;
    s2_entry_t           s2, s2_d;
    logic                unused_instr;

    assign unused_instr = ^issue_instr_i[24:15];

    int8_dot4 u_dot (
        .a_i    (issue_rs1_i),
        .b_i    (issue_rs2_i),
        .prod_o (prod)
    );

    // Only funct3 values 0..3 are defined, i.e. funct3[2] must be clear.
    assign known          = issue_instr_i[6:0] == OPCODE_CUSTOM0 &&
                            issue_instr_i[31:25] == FUNCT7_DOT4 && !issue_instr_i[14];
    assign dec_op         = op_e'(issue_instr_i[13:12]);
    assign issue_accept_o = rst_ni && issue_valid_i && known;
    assign advance        = !s2_valid || result_ready_i;
    assign issue_ready_o  = advance || !s1_valid;

    // S2 result and next accumulator, both from the S1 entry and the current acc,
    // so back-to-back MAC4/ACCRD see every prior update with no bubble.
    always_comb begin
        dot     = sum4(s1.prod);
        mac     = acc + dot;
        s2_d.data = s1.op == OP_DOT4  ? dot :
                    s1.op == OP_MAC4  ? mac :
                    s1.op == OP_ACCRD ? acc :
                    (s1.rs1[31] ? 32'd0 : s1.rs1);
        s2_d.rd = s1.rd;
        s2_d.we = s1.rd != 5'd0;
        acc_d   = s1.op == OP_MAC4  ? mac :
                  s1.op == OP_ACCRD ? 32'd0 : acc;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2       <= '0;
            s2_id    <= '0;
            acc      <= '0;
        end else begin
            // An unaccepted handshake still loads S1, but as an empty slot.
            if (issue_ready_o) begin
                s1_valid <= issue_accept_o;
                s1       <= '{op: dec_op, prod: prod, rd: issue_instr_i[11:7], rs1: issue_rs1_i};
                s1_id    <= issue_id_i;
            end
            if (advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2    <= s2_d;
                    s2_id <= s1_id;
                    acc   <= acc_d;
                end
            end
        end
    end

    assign result_valid_o = s2_valid;
    assign result_id_o    = s2_id;
    assign result_data_o  = s2.data;
    assign result_rd_o    = s2.rd;
    assign result_we_o    = s2.we;

endmodule

// File: tb/tb_cvxif_dot4_copro.sv
// tb_cvxif_dot4_copro: self-checking bench for cvxif_dot4_copro
module tb_cvxif_dot4_copro;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic [31:0] issue_rs1_i = '0;
    logic [31:0] issue_rs2_i = '0;
    logic [3:0]  issue_id_i = '0;
    logic        issue_accept_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b1;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cvxif_dot4_copro #(.XLEN(32), .ID_WIDTH(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_instr_i  (issue_instr_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .issue_id_i     (issue_id_i),
        .issue_accept_o (issue_accept_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_data_o  (result_data_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  id;
        logic        acc;
        logic [31:0] data;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[13];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 10'd0, f3, rd, op};
    endfunction

    // Scoreboard: every accepted result leaving the block must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_ni && result_valid_o && result_ready_i) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual id=%h data=%h expected none", result_id_o, result_data_o);
            end else begin
                chk("result", {result_id_o, result_data_o, result_rd_o, result_we_o}, sbq.pop_front());
            end
        end
    end

    // Starts and ends near a negedge; issue_valid is held until the handshake edge has passed.
    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] id, input logic exp_acc, input logic [31:0] exp_data);
        int n;
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_rs1_i   = rs1;
        issue_rs2_i   = rs2;
        issue_id_i    = id;
        #1;
        n = 0;
        while (!issue_ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual ready=0 expected ready=1 id=%h", id);
        end
        chk("accept", issue_accept_o, exp_acc);
        if (exp_acc) sbq.push_back('{id, exp_data, instr[11:7], instr[11:7] != 5'd0});
        @(negedge clk);
        issue_valid_i = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        result_ready_i = v;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    localparam logic [6:0] OP = 7'h0B;

    initial begin
        tbl[0]  = '{enc(0, 3'd0, 5'd5, OP), 32'h01020304, 32'h01010101, 4'd1,  1'b1, 32'h0000000A};
        tbl[1]  = '{enc(0, 3'd0, 5'd5, OP), 32'hFF807F01, 32'h02020202, 4'd2,  1'b1, 32'hFFFFFFFE};
        tbl[2]  = '{enc(0, 3'd3, 5'd0, OP), 32'h80000000, 32'h0,        4'd3,  1'b1, 32'h00000000};
        tbl[3]  = '{enc(0, 3'd3, 5'd9, OP), 32'h7FFFFFFF, 32'h0,        4'd4,  1'b1, 32'h7FFFFFFF};
        tbl[4]  = '{enc(0, 3'd1, 5'd1, OP), 32'h01010101, 32'h01010101, 4'd5,  1'b1, 32'd4};
        tbl[5]  = '{enc(0, 3'd1, 5'd1, OP), 32'h01010101, 32'h01010101, 4'd6,  1'b1, 32'd8};
        tbl[6]  = '{enc(0, 3'd1, 5'd1, OP), 32'h01010101, 32'h01010101, 4'd7,  1'b1, 32'd12};
        tbl[7]  = '{enc(0, 3'd1, 5'd1, 7'h33), 32'h01010101, 32'h01010101, 4'd8, 1'b0, 32'd0};
        tbl[8]  = '{enc(7'h01, 3'd1, 5'd1, OP), 32'h01010101, 32'h01010101, 4'd9, 1'b0, 32'd0};
        tbl[9]  = '{enc(0, 3'd4, 5'd1, OP), 32'h01010101, 32'h01010101, 4'd10, 1'b0, 32'd0};
        tbl[10] = '{enc(0, 3'd2, 5'd2, OP), 32'h0,        32'h0,        4'd11, 1'b1, 32'd12};
        tbl[11] = '{enc(0, 3'd2, 5'd2, OP), 32'h0,        32'h0,        4'd12, 1'b1, 32'd0};
        tbl[12] = '{enc(0, 3'd0, 5'd31, OP), 32'h80808080, 32'h7F7F7F7F, 4'd13, 1'b1, 32'hFFFF0200};

        // Reset state with a valid instruction presented.
        issue_valid_i = 1'b1;
        issue_instr_i = enc(0, 3'd0, 5'd5, OP);
        repeat (2) @(negedge clk);
        chk("rst_accept", issue_accept_o, 1'b0);
        chk("rst_result_valid", result_valid_o, 1'b0);
        chk("rst_result_fields", {result_id_o, result_data_o, result_rd_o, result_we_o}, 0);
        issue_valid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        chk("rst_release_ready", issue_ready_o, 1'b1);
        @(negedge clk);

        // Latency: result appears exactly two cycles after the handshake.
        issue(enc(0, 3'd0, 5'd5, OP), 32'h01020304, 32'h01010101, 4'd14, 1'b1, 32'h0000000A);
        chk("lat_not_yet", result_valid_o, 1'b0);
        @(negedge clk);
        chk("lat_valid", result_valid_o, 1'b1);
        chk("lat_id_data", {result_id_o, result_data_o}, {4'd14, 32'h0000000A});
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            issue(tbl[i].instr, tbl[i].rs1, tbl[i].rs2, tbl[i].id, tbl[i].acc, tbl[i].data);
        drain();

        // Backpressure: two entries fill the pipe, the third waits, outputs hold.
        set_ready(1'b0);
        @(negedge clk);
        issue(enc(0, 3'd0, 5'd3, OP), 32'h00000001, 32'h00000001, 4'd1, 1'b1, 32'd1);
        issue(enc(0, 3'd0, 5'd3, OP), 32'h00000002, 32'h00000001, 4'd2, 1'b1, 32'd2);
        chk("stall_ready_low", issue_ready_o, 1'b0);
        issue_valid_i = 1'b1;
        issue_instr_i = enc(0, 3'd0, 5'd3, OP);
        issue_rs1_i   = 32'h00000003;
        issue_rs2_i   = 32'h00000001;
        issue_id_i    = 4'd3;
        sbq.push_back('{4'd3, 32'd3, 5'd3, 1'b1});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready_hold", issue_ready_o, 1'b0);
            chk("stall_out_hold", {result_valid_o, result_id_o, result_data_o}, {1'b1, 4'd1, 32'd1});
        end
        set_ready(1'b1);
        @(negedge clk);
        chk("release_1", {result_valid_o, result_id_o}, {1'b1, 4'd1});
        @(negedge clk);
        issue_valid_i = 1'b0;
        chk("release_2", {result_valid_o, result_id_o}, {1'b1, 4'd2});
        @(negedge clk);
        chk("release_3", {result_valid_o, result_id_o}, {1'b1, 4'd3});
        drain();

        // Reset with both stages full and acc=7 discards everything.
        @(negedge clk);
        issue(enc(0, 3'd1, 5'd4, OP), 32'h00000007, 32'h00000001, 4'd4, 1'b1, 32'd7);
        drain();
        set_ready(1'b0);
        @(negedge clk);
        issue(enc(0, 3'd0, 5'd4, OP), 32'h00000005, 32'h00000001, 4'd5, 1'b1, 32'd5);
        issue(enc(0, 3'd0, 5'd4, OP), 32'h00000006, 32'h00000001, 4'd6, 1'b1, 32'd6);
        chk("prereset_full", {result_valid_o, issue_ready_o}, {1'b1, 1'b0});
        rst_ni = 1'b0;
        sbq.delete();
        #1;
        chk("reset_flush", {result_valid_o, result_data_o}, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        set_ready(1'b1);
        repeat (4) @(negedge clk);
        issue(enc(0, 3'd2, 5'd6, OP), 32'h0, 32'h0, 4'd7, 1'b1, 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cvxif_dot4_copro.md
CVXIF_DOT4_COPRO -- requirements
Module: cvxif_dot4_copro

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, as the operand and result width; only 32 is supported.
REQ-002 The block SHALL expose parameter ID_WIDTH, default 4, as the instruction tag width.
REQ-003 The block SHALL have clk_i, input, 1 bit, as its single clock.
REQ-004 The block SHALL have rst_ni, input, 1 bit, as its reset, which is asynchronous and active-low.
REQ-005 The block SHALL have issue_valid_i, input, 1 bit: an offloaded instruction is presented.
REQ-006 The block SHALL have issue_ready_o, output, 1 bit: the block can take the presented instruction.
REQ-007 The block SHALL have issue_instr_i, input, 32 bits: the raw instruction word.
REQ-008 The block SHALL have issue_rs1_i and issue_rs2_i, inputs, XLEN bits each: the source operand values.
REQ-009 The block SHALL have issue_id_i, input, ID_WIDTH bits: the instruction tag.
REQ-010 The block SHALL have issue_accept_o, output, 1 bit: the instruction is recognised and will produce a result.
REQ-011 The block SHALL have result_valid_o, output, 1 bit, and result_ready_i, input, 1 bit: the result handshake.
REQ-012 The block SHALL have result_id_o, output, ID_WIDTH bits; result_data_o, output, XLEN bits; result_rd_o, output, 5 bits; and result_we_o, output, 1 bit.

Function
REQ-013 The block SHALL recognise an instruction only when opcode[6:0]=7'h0B and funct7=0; funct3 selects the operation.
- 000 DOT4: rd = signed dot product of the four int8 byte lanes of rs1 and rs2.
- 001 MAC4: acc += DOT4; rd = the new acc.
- 010 ACCRD: rd = acc, then acc = 0.
- 011 RELU: rd = rs1 if rs1 is non-negative, else 0.
REQ-014 An issue handshake SHALL complete when issue_valid_i and issue_ready_o are both high in the same cycle.
REQ-015 issue_accept_o SHALL be combinational and valid while issue_valid_i is high; it SHALL be 0 for any other encoding.
REQ-016 An unaccepted instruction SHALL still complete its handshake, SHALL produce no result, and SHALL leave acc unchanged.
REQ-017 The datapath SHALL be two registered stages.
- S1 registers the four 16-bit signed products, the operation, id, rd and rs1.
- S2 registers the result, id, rd and we.
REQ-018 result_valid_o SHALL rise exactly 2 cycles after an accepted handshake when there is no backpressure.
REQ-019 The pipeline SHALL advance when (!s2_valid || result_ready_i).
REQ-020 issue_ready_o SHALL equal advance || !s1_valid.
REQ-021 While stalled, the S2 outputs SHALL hold stable.
REQ-022 Results SHALL leave strictly in issue order.
REQ-023 At sustained throughput the block SHALL complete one instruction per cycle.
REQ-024 The 32-bit accumulator acc SHALL update only in the S1-to-S2 transfer cycle.
REQ-025 Back-to-back MAC4/ACCRD instructions SHALL therefore observe every earlier acc update with no bubble.
REQ-026 All sums SHALL sign-extend products to 32 bits and wrap modulo 2^32; overflow SHALL NOT be flagged.
REQ-027 result_we_o SHALL be 1 iff rd != 0; result_rd_o SHALL equal instr[11:7].
REQ-028 A simultaneous S2 drain and S1 fill SHALL lose no entry.

Reset
REQ-029 While rst_ni=0, s1_valid, s2_valid, result_valid_o, issue_accept_o, acc and all result fields SHALL be 0.
REQ-030 On release of rst_ni, issue_ready_o SHALL be 1.
REQ-031 Assertion of reset during an in-flight operation SHALL discard that operation without emitting a result.

Structure
REQ-032 Opcode, funct3 encodings, the operation enum and the S1/S2 entry structs SHALL live in a shared package, mnist_cvxif_pkg.
REQ-033 XLEN SHALL be taken from CVA6ConfigXlen.
REQ-034 One sub-module, int8_dot4, SHALL hold the four signed 8x8 multipliers; the S1 register stays in the top level.

Verification
REQ-035 DOT4 with rs1=0x01020304 and rs2=0x01010101 -> result_data_o=0x0000000A, 2 cycles after the handshake, with the matching id.
REQ-036 DOT4 with rs1=0xFF807F01 and rs2=0x02020202 -> 0xFFFFFFFE.
REQ-037 Three back-to-back MAC4 ops with operands 0x01010101/0x01010101, then ACCRD -> results 4, 8, 12, 12; a following ACCRD -> 0.
REQ-038 result_ready_i low for 5 cycles with ids 1, 2, 3 issued -> issue_ready_o drops after 2 entries and outputs hold; on release, results emerge 1, 2, 3 in consecutive cycles.
REQ-039 Opcode 0x33, or funct7 != 0 -> issue_accept_o=0, the handshake completes, no result_valid_o, acc unchanged.
REQ-040 rst_ni pulsed low with S1 and S2 valid and acc=7 -> no result emitted, and a subsequent ACCRD returns 0.
